// File: rtl/addr_sel_pkg.sv
// addr_sel_pkg: shared constants, types and helpers for the register-address
// selector (addr_sel_arb) and its grant logic (addr_sel_rr_arb).
package addr_sel_pkg;

  localparam int AW_DEF    = 3;
  localparam int N_SRC_MAX = 8;

  typedef logic [AW_DEF-1:0] rf_addr_t;

  // Output register stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Index width for n sources; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr_sel_rr_arb.sv
// addr_sel_rr_arb: one-hot grant from a request vector. Fixed priority
// (index 0 highest) when RR_MODE=0, otherwise round-robin starting at rr_ptr.
// rr_ptr moves to one past the granted index whenever adv is high.
module addr_sel_rr_arb
  import addr_sel_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int RR_MODE = 0,
  localparam int IW     = idx_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             adv,
  output logic [N_SRC-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW-1:0] rr_ptr;
  logic          found;

  // Scan the requests starting at rr_ptr (or at 0 for fixed priority); first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      int cand;
      cand = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  // Round-robin pointer: step past the winner on each advancing grant, wrap at N_SRC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((RR_MODE != 0) && adv) begin
      if (int'(gnt_idx) == N_SRC - 1) rr_ptr <= '0;
      else                            rr_ptr <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/addr_sel_arb.sv
// addr_sel_arb: N-source register-address selector with a single registered
// output stage and valid/ready handshake on both sides.
// Optional feature macro: ADDR_SEL_LOCK_EN adds src_lock, which pins the grant
// to the most recently accepted source and freezes the round-robin pointer.
module addr_sel_arb
  import addr_sel_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int AW      = AW_DEF,
  parameter int RR_MODE = 0,
  localparam int IW     = idx_w(N_SRC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [N_SRC*AW-1:0] src_addr,
  output logic [N_SRC-1:0]    src_ready,
  input  logic                out_ready,
`ifdef ADDR_SEL_LOCK_EN
  input  logic                src_lock,
`endif
  output logic                out_valid,
  output logic [AW-1:0]       out_addr,
  output logic [IW-1:0]       out_src
);

  out_state_t       state, state_next;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             can_load;
  logic             accept;
  logic             adv;
  logic [AW-1:0]    addr_arr [N_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
      assign addr_arr[gi] = src_addr[gi*AW +: AW];
    end
  endgenerate

  // out_ready only reaches src_ready through can_load; outputs are all registered.
  assign out_valid = (state == ST_FULL);
  assign can_load  = (state == ST_EMPTY) || out_ready;
  assign src_ready = gnt & {N_SRC{can_load}};
  assign accept    = |src_ready;

`ifdef ADDR_SEL_LOCK_EN
  logic [IW-1:0] last_grant;

  // While locked only the last accepted source may request; pointer stays put.
  assign req = src_lock ? (src_valid & (N_SRC'(1) << last_grant)) : src_valid;
  assign adv = accept & ~src_lock;

  // Remember which source was accepted most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= '0;
    else if (accept) last_grant <= gnt_idx;
  end
`else
  assign req = src_valid;
  assign adv = accept;
`endif

  addr_sel_rr_arb #(
    .N_SRC   (N_SRC),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .adv     (adv),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Output stage occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  // Fill on accept; drain when the consumer takes the entry and nothing replaces it.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept)               state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:                            state_next = ST_EMPTY;
    endcase
  end

  // Capture the granted address and source index; hold them otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr <= '0;
      out_src  <= '0;
    end else if (accept) begin
      out_addr <= addr_arr[gnt_idx];
      out_src  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_addr_sel_arb.sv
// tb_addr_sel_arb: directed and randomized checks of addr_sel_arb in two
// configurations (2-source fixed priority, 4-source round-robin) against a
// behavioural model of the selection rules.
module tb_addr_sel_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 2-source fixed-priority instance
  logic [1:0] a_valid, a_ready;
  logic [5:0] a_addr;
  logic       a_or, a_ov;
  logic [2:0] a_oa;
  logic [0:0] a_os;

  // 4-source round-robin instance
  logic [3:0]  b_valid, b_ready;
  logic [11:0] b_addr;
  logic        b_or, b_ov;
  logic [2:0]  b_oa;
  logic [1:0]  b_os;

`ifdef ADDR_SEL_LOCK_EN
  logic a_lock, b_lock;
`endif

  addr_sel_arb #(.N_SRC(2), .AW(3), .RR_MODE(0)) u_dut_pri (
    .clk       (clk),
    .rst       (rst),
    .src_valid (a_valid),
    .src_addr  (a_addr),
    .src_ready (a_ready),
    .out_ready (a_or),
`ifdef ADDR_SEL_LOCK_EN
    .src_lock  (a_lock),
`endif
    .out_valid (a_ov),
    .out_addr  (a_oa),
    .out_src   (a_os)
  );

  addr_sel_arb #(.N_SRC(4), .AW(3), .RR_MODE(1)) u_dut_rr (
    .clk       (clk),
    .rst       (rst),
    .src_valid (b_valid),
    .src_addr  (b_addr),
    .src_ready (b_ready),
    .out_ready (b_or),
`ifdef ADDR_SEL_LOCK_EN
    .src_lock  (b_lock),
`endif
    .out_valid (b_ov),
    .out_addr  (b_oa),
    .out_src   (b_os)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int ma_ov, ma_oa, ma_os;
  int mb_ov, mb_oa, mb_os, mb_ptr, mb_last;
  int exp_ra, exp_rb;
  logic [1:0] got_ra;
  logic [3:0] got_rb;

  // winner under the arbitration rules; -1 when nobody is valid
  function automatic int pick(input int n, input int rr, input int ptr, input logic [7:0] v);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (rr != 0) ? (ptr + k) % n : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ma_ov = 0; ma_oa = 0; ma_os = 0;
    mb_ov = 0; mb_oa = 0; mb_os = 0; mb_ptr = 0; mb_last = 0;
  endtask

  // One clock: sample ready before the edge, advance the model, return at negedge.
  task automatic cycle();
    int ga, gb, lockb;
    bit acc_a, acc_b;
    #1;
    got_ra = a_ready;
    got_rb = b_ready;
    ga = pick(2, 0, 0, {6'b0, a_valid});
    acc_a = (ga >= 0) && (ma_ov == 0 || a_or);
    exp_ra = acc_a ? (1 << ga) : 0;
    lockb = 0;
`ifdef ADDR_SEL_LOCK_EN
    lockb = int'(b_lock);
`endif
    if (lockb != 0) gb = b_valid[mb_last] ? mb_last : -1;
    else            gb = pick(4, 1, mb_ptr, {4'b0, b_valid});
    acc_b = (gb >= 0) && (mb_ov == 0 || b_or);
    exp_rb = acc_b ? (1 << gb) : 0;
    @(posedge clk);
    if (acc_a) begin
      ma_ov = 1; ma_oa = int'(a_addr[ga*3 +: 3]); ma_os = ga;
    end else if (a_or) begin
      ma_ov = 0;
    end
    if (acc_b) begin
      mb_ov = 1; mb_oa = int'(b_addr[gb*3 +: 3]); mb_os = gb; mb_last = gb;
      if (lockb == 0) mb_ptr = (gb + 1) % 4;
    end else if (b_or) begin
      mb_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_valid = '0; a_addr = '0; a_or = 1'b1;
    b_valid = '0; b_addr = '0; b_or = 1'b1;
`ifdef ADDR_SEL_LOCK_EN
    a_lock = 1'b0; b_lock = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_a_valid got=%b exp=0", a_ov); end
    checks++; if (a_oa !== 3'd0) begin errors++; $display("FAIL reset_a_addr got=%0d exp=0", a_oa); end
    checks++; if (a_os !== 1'd0) begin errors++; $display("FAIL reset_a_src got=%0d exp=0", a_os); end
    checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL reset_b_valid got=%b exp=0", b_ov); end
    checks++; if (b_oa !== 3'd0) begin errors++; $display("FAIL reset_b_addr got=%0d exp=0", b_oa); end
    checks++; if (b_os !== 2'd0) begin errors++; $display("FAIL reset_b_src got=%0d exp=0", b_os); end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_legacy();
    a_valid = 2'b11; a_addr = {3'd2, 3'd5}; a_or = 1'b1;
    cycle();
    checks++; if (got_ra !== 2'b01) begin errors++; $display("FAIL legacy_ready got=%b exp=01", got_ra); end
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL legacy_valid got=%b exp=1", a_ov); end
    checks++; if (a_oa !== 3'd5) begin errors++; $display("FAIL legacy_addr got=%0d exp=5", a_oa); end
    checks++; if (a_os !== 1'd0) begin errors++; $display("FAIL legacy_src got=%0d exp=0", a_os); end
    $display("test_legacy addr=%0d src=%0d", a_oa, a_os);
  endtask

  task automatic test_backpressure();
    a_or = 1'b0; a_valid = 2'b11; a_addr = {3'd4, 3'd7};
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (got_ra !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=00", i, got_ra); end
      checks++; if (a_oa !== 3'd5 || a_ov !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got=%0d/%b exp=5/1", i, a_oa, a_ov);
      end
      $display("test_backpressure stall %0d addr=%0d", i, a_oa);
    end
    a_or = 1'b1;
    cycle();
    checks++; if (got_ra !== 2'b01) begin errors++; $display("FAIL release_ready got=%b exp=01", got_ra); end
    checks++; if (a_oa !== 3'd7) begin errors++; $display("FAIL release_addr got=%0d exp=7", a_oa); end
    a_valid = 2'b00;
    cycle();
    checks++; if (a_ov !== 1'b0 || a_oa !== 3'd7) begin
      errors++; $display("FAIL drain got=%b/%0d exp=0/7", a_ov, a_oa);
    end
    $display("test_backpressure drained valid=%b addr=%0d", a_ov, a_oa);
  endtask

  task automatic test_rr_sequence();
    b_valid = 4'b1111; b_addr = {3'd4, 3'd3, 3'd2, 3'd1}; b_or = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (b_os !== 2'(i % 4) || b_oa !== 3'(i % 4 + 1) || b_ov !== 1'b1) begin
        errors++; $display("FAIL rr_seq[%0d] got src=%0d addr=%0d v=%b exp src=%0d addr=%0d v=1",
                           i, b_os, b_oa, b_ov, i % 4, i % 4 + 1);
      end
      checks++; if (got_rb !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, got_rb, 4'(1 << (i % 4)));
      end
      $display("test_rr_sequence %0d src=%0d addr=%0d", i, b_os, b_oa);
    end
  endtask

  task automatic test_sparse_rr();
    b_valid = 4'b0100; b_addr = {3'd0, 3'd5, 3'd0, 3'd0};
    cycle();  // grant 2, pointer to 3
    checks++; if (b_os !== 2'd2) begin errors++; $display("FAIL sparse_setup got=%0d exp=2", b_os); end
    b_valid = 4'b0010; b_addr = {3'd0, 3'd0, 3'd6, 3'd0};
    cycle();
    checks++; if (b_os !== 2'd1 || b_oa !== 3'd6) begin
      errors++; $display("FAIL sparse_grant got src=%0d addr=%0d exp src=1 addr=6", b_os, b_oa);
    end
    b_valid = 4'b1111; b_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    cycle();  // pointer should now be 2
    checks++; if (b_os !== 2'd2) begin errors++; $display("FAIL sparse_ptr got=%0d exp=2", b_os); end
    b_valid = 4'b0000;
    cycle();
    $display("test_sparse_rr src=%0d", b_os);
  endtask

`ifdef ADDR_SEL_LOCK_EN
  task automatic test_lock();
    b_valid = 4'b0100; b_addr = {3'd0, 3'd3, 3'd0, 3'd1};
    cycle();
    b_lock = 1'b1; b_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (b_os !== 2'd2 || got_rb !== 4'b0100) begin
        errors++; $display("FAIL lock_hold[%0d] got src=%0d rdy=%b exp src=2 rdy=0100", i, b_os, got_rb);
      end
      $display("test_lock locked %0d src=%0d", i, b_os);
    end
    b_lock = 1'b0;
    cycle();
    checks++; if (b_os !== 2'd0) begin errors++; $display("FAIL lock_release got=%0d exp=0", b_os); end
    b_valid = 4'b0000;
    cycle();
  endtask
`endif

  task automatic test_random();
    int bad;
    for (int i = 0; i < 400; i++) begin
      a_valid = 2'($urandom); a_addr = 6'($urandom); a_or = ($urandom_range(0, 3) != 0);
      b_valid = 4'($urandom); b_addr = 12'($urandom); b_or = ($urandom_range(0, 3) != 0);
`ifdef ADDR_SEL_LOCK_EN
      b_lock = ($urandom_range(0, 3) == 0);
`endif
      cycle();
      bad = 0;
      checks++; if (got_ra !== 2'(exp_ra) || a_ov !== 1'(ma_ov) || a_oa !== 3'(ma_oa) || a_os !== 1'(ma_os)) begin
        errors++; bad = 1;
        $display("FAIL rand_a[%0d] got rdy=%b v=%b addr=%0d src=%0d exp rdy=%b v=%0d addr=%0d src=%0d",
                 i, got_ra, a_ov, a_oa, a_os, 2'(exp_ra), ma_ov, ma_oa, ma_os);
      end
      checks++; if (got_rb !== 4'(exp_rb) || b_ov !== 1'(mb_ov) || b_oa !== 3'(mb_oa) || b_os !== 2'(mb_os)) begin
        errors++; bad = 1;
        $display("FAIL rand_b[%0d] got rdy=%b v=%b addr=%0d src=%0d exp rdy=%b v=%0d addr=%0d src=%0d",
                 i, got_rb, b_ov, b_oa, b_os, 4'(exp_rb), mb_ov, mb_oa, mb_os);
      end
      if (bad == 0)
        $display("rand %0d a: v=%b addr=%0d src=%0d b: v=%b addr=%0d src=%0d", i, a_ov, a_oa, a_os, b_ov, b_oa, b_os);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    a_valid = 2'b10; a_addr = {3'd6, 3'd0}; a_or = 1'b0;
    b_valid = 4'b1000; b_addr = {3'd7, 9'd0}; b_or = 1'b0;
    cycle();
    checks++; if (a_ov !== 1'b1 || b_ov !== 1'b1) begin
      errors++; $display("FAIL midrst_setup got=%b/%b exp=1/1", a_ov, b_ov);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_ov !== 1'b0 || a_oa !== 3'd0 || a_os !== 1'd0) begin
      errors++; $display("FAIL midrst_a got v=%b addr=%0d src=%0d exp 0/0/0", a_ov, a_oa, a_os);
    end
    checks++; if (b_ov !== 1'b0 || b_oa !== 3'd0 || b_os !== 2'd0) begin
      errors++; $display("FAIL midrst_b got v=%b addr=%0d src=%0d exp 0/0/0", b_ov, b_oa, b_os);
    end
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    b_valid = 4'b1111; b_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    cycle();
    checks++; if (b_os !== 2'd0 || b_oa !== 3'd1) begin
      errors++; $display("FAIL midrst_ptr got src=%0d addr=%0d exp src=0 addr=1", b_os, b_oa);
    end
    $display("test_reset_mid src=%0d addr=%0d", b_os, b_oa);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_legacy();
    test_backpressure();
    test_rr_sequence();
    test_sparse_rr();
`ifdef ADDR_SEL_LOCK_EN
    test_lock();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
